// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: WIDTH/STAGES-bit slices are carry-chained across
// STAGES registers, with a valid/ready handshake and carry/overflow/zero/negative flags.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int W    = WIDTH / STAGES;
  localparam int NOPS = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, STAGES >= 1");
  end

  // Per-stage registers. The operands only need to travel to the stages that
  // still have slices left to compute, so the last stage keeps none.
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  part   [STAGES];
  logic [STAGES-1:0] cy;
  logic [WIDTH-1:0]  op_a   [NOPS];
  logic [WIDTH-1:0]  op_b   [NOPS];
  logic [NOPS-1:0]   op_sub;
  logic              ovf_q;
  logic              zero_q;
  logic              neg_q;

  logic [WIDTH-1:0]  src_a  [STAGES];
  logic [WIDTH-1:0]  src_b  [STAGES];
  logic [WIDTH-1:0]  src_r  [STAGES];
  logic [STAGES-1:0] src_s;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  nxt_r  [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [W-1:0]      bx;
  logic [W:0]        slice_sum;
  logic              cmsb;
  logic              advance;

  assign out_valid = vld[STAGES-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  always_comb begin
    bx        = '0;
    slice_sum = '0;
    src_a[0]  = a;
    src_b[0]  = b;
    src_r[0]  = '0;
    src_s[0]  = sub;
    src_c[0]  = sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k] = op_a[k-1];
      src_b[k] = op_b[k-1];
      src_r[k] = part[k-1];
      src_s[k] = op_sub[k-1];
      src_c[k] = cy[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      bx        = src_b[k][k*W +: W] ^ {W{src_s[k]}};
      slice_sum = {1'b0, src_a[k][k*W +: W]} + {1'b0, bx} + {{W{1'b0}}, src_c[k]};
      nxt_r[k]  = src_r[k];
      nxt_r[k][k*W +: W] = slice_sum[W-1:0];
      nxt_c[k]  = slice_sum[W];
    end
    // bx/slice_sum now hold the last stage; the MSB sum bit is a^b^cin,
    // so the carry into the MSB falls out of those three bits.
    cmsb = slice_sum[W-1] ^ src_a[STAGES-1][WIDTH-1] ^ bx[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      cy     <= '0;
      op_sub <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        part[k] <= '0;
      end
      for (int unsigned k = 0; k < NOPS; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (advance) begin
        vld[0] <= in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
          vld[k] <= vld[k-1];
        end
      end
      if (advance) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          part[k] <= nxt_r[k];
          cy[k]   <= nxt_c[k];
        end
        for (int unsigned k = 0; k + 1 < STAGES; k++) begin
          op_a[k]   <= src_a[k];
          op_b[k]   <= src_b[k];
          op_sub[k] <= src_s[k];
        end
        ovf_q  <= nxt_c[STAGES-1] ^ cmsb;
        zero_q <= (nxt_r[STAGES-1] == '0);
        neg_q  <= nxt_r[STAGES-1][WIDTH-1];
      end
    end
  end

  assign result   = part[STAGES-1];
  assign carry    = cy[STAGES-1];
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed cases on a 32/4 instance plus
// randomized handshake traffic on 16-bit instances with 1, 2 and 8 stages.
module tb_pipelined_addsub;

  typedef struct {
    longint unsigned r;
    bit c, v, z, n;
  } exp_t;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, sub, out_valid, out_ready;
  logic        carry, overflow, zero, negative;
  logic [31:0] a, b, result;
  logic        rand_go = 1'b0;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(int unsigned w, longint unsigned x, longint unsigned y, bit s);
    exp_t e;
    longint unsigned m = 64'd1 << w;
    longint unsigned h = m >> 1;
    longint sx, sy, sr;
    x = x % m;
    y = y % m;
    if (!s) begin
      e.r = (x + y) % m;
      e.c = (x + y) >= m;
    end else begin
      e.r = (x + m - y) % m;
      e.c = x >= y;
    end
    sx = (x >= h) ? longint'(x) - longint'(m) : longint'(x);
    sy = (y >= h) ? longint'(y) - longint'(m) : longint'(y);
    sr = s ? sx - sy : sx + sy;
    e.v = (sr < -longint'(h)) || (sr >= longint'(h));
    e.z = (e.r == 0);
    e.n = (e.r >= h);
    return e;
  endfunction

  function automatic longint unsigned pack(exp_t e);
    return (e.r << 4) | 64'({e.c, e.v, e.z, e.n});
  endfunction

  task automatic chk(string name, longint unsigned got, longint unsigned want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Main-instance scoreboard and monitor
  exp_t        q[$];
  exp_t        me, mo;
  int unsigned delivered = 0;
  bit          prev_stall = 1'b0;
  logic [35:0] prev_obs;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {out_valid, result, carry, overflow, zero, negative}, {1'b1, prev_obs});
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          me = q.pop_front();
          mo.r = result; mo.c = carry; mo.v = overflow; mo.z = zero; mo.n = negative;
          chk("result", pack(mo), pack(me));
          delivered++;
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_obs   = {result, carry, overflow, zero, negative};
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(32, a, b, sub));
    end
  end

  task automatic step(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 199) chk("send_timeout", 1, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t <= 100; t++) begin
      if (q.size() == 0 && !out_valid) break;
      if (t == 100) chk("drain_timeout", q.size(), 0);
      step(1);
    end
  endtask

  logic [31:0] ta [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h1234, 32'd0};
  logic [31:0] tbv[6] = '{32'd1,        32'd1,        32'd5, 32'd1,        32'h1234, 32'd0};
  logic        ts [6] = '{1'b0,         1'b0,         1'b1,  1'b1,         1'b1,     1'b1};
  int unsigned n, base, cnt;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    step(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result_flags", {result, carry, overflow, zero, negative}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // single op: latency and value
    a = 32'd5; b = 32'd7; sub = 1'b0; in_valid = 1'b1; n = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n++;
      if (out_valid) break;
    end
    chk("latency", n, 4);
    chk("first_result", {result, carry, overflow, zero, negative}, {32'd12, 4'b0000});
    drain();

    // arithmetic corners
    for (int i = 0; i < 6; i++) begin
      send(ta[i], tbv[i], ts[i]);
      drain();
    end

    // back-to-back stream
    base = delivered;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom));
    chk("stream_mid", delivered - base, 4);
    step(4);
    chk("stream_end", delivered - base, 8);
    drain();

    // stream with a 3-cycle downstream stall
    base = delivered;
    fork
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom));
      begin
        step(6);
        out_ready = 1'b0;
        step(3);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", delivered - base, 8);

    // flush with 3 in flight plus an accept in the flush cycle
    for (int i = 0; i < 3; i++) send(32'd100 + i, 32'd1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; a = 32'hDEAD; b = 32'h1;
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      step(1);
      if (out_valid) cnt++;
    end
    chk("flush_no_out", cnt, 0);

    // async reset mid-stream
    for (int i = 0; i < 3; i++) send(32'd200 + i, 32'd2, 1'b1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result_flags", {result, carry, overflow, zero, negative}, 0);
    step(1);
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      step(1);
      if (out_valid) cnt++;
    end
    chk("midrst_no_out", cnt, 0);

    rand_go = 1'b1;
    for (int t = 0; t < 60000; t++) begin
      if (gen_rand[0].done && gen_rand[1].done && gen_rand[2].done) break;
      step(1);
    end
    chk("rand_done", {gen_rand[0].done, gen_rand[1].done, gen_rand[2].done}, 3'b111);
    chk("main_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Randomized traffic, WIDTH=16, STAGES in {1,2,8}
  for (genvar g = 0; g < 3; g++) begin : gen_rand
    localparam int          ST   = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    localparam int unsigned NOPS = (g == 2) ? 3334 : 3333;

    logic        iv, ir, ov, ordy, sb, fl, c, v, z, n, acc, done;
    logic [15:0] ia, ib, res;
    exp_t        rq[$];
    exp_t        re, ro;
    int unsigned sent;

    pipelined_addsub #(.WIDTH(16), .STAGES(ST)) dut_r (
      .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_ready(ir),
      .a(ia), .b(ib), .sub(sb), .out_valid(ov), .out_ready(ordy),
      .result(res), .carry(c), .overflow(v), .zero(z), .negative(n)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        rq.delete();
      end else begin
        if (ov && ordy) begin
          if (rq.size() == 0) begin
            chk($sformatf("rand_st%0d_unexpected", ST), 1, 0);
          end else begin
            re = rq.pop_front();
            ro.r = res; ro.c = c; ro.v = v; ro.z = z; ro.n = n;
            chk($sformatf("rand_st%0d", ST), pack(ro), pack(re));
          end
        end
        if (iv && ir) begin
          rq.push_back(model(16, ia, ib, sb));
          acc = 1'b1;
        end
      end
    end

    initial begin
      iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; sb = 1'b0; fl = 1'b0; acc = 1'b0; done = 1'b0;
      sent = 0;
      wait (rand_go);
      @(posedge clk);
      #1;
      while (sent < NOPS) begin
        @(posedge clk);
        #1;
        if (acc) begin
          acc = 1'b0;
          iv = 1'b0;
          sent++;
        end
        if (!iv && sent < NOPS && $urandom_range(3) != 0) begin
          iv = 1'b1;
          ia = 16'($urandom);
          ib = 16'($urandom);
          sb = 1'($urandom);
          if ($urandom_range(7) == 0) ia = ($urandom_range(1) == 0) ? 16'h8000 : 16'h7FFF;
          if ($urandom_range(7) == 0) ib = ($urandom_range(1) == 0) ? 16'hFFFF : 16'h0000;
        end
        ordy = ($urandom_range(3) != 0);
      end
      ordy = 1'b1;
      for (int t = 0; t <= 200; t++) begin
        if (rq.size() == 0) break;
        if (t == 200) chk($sformatf("rand_st%0d_drain", ST), rq.size(), 0);
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

endmodule
